// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_seq
//  Purpose  : Sequential signed 32x32 multiplier (Booth radix-2) and signed
//             32/32 divider (restoring, on magnitudes). Results land in the
//             HI/LO output registers with a one-cycle done/write pulse.
//  Options  : MULT_DIV_SEQ_ZERO_FAST_EN - when defined, a multiply with a zero
//             operand completes one cycle after acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        hi_lo_write,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: upper partial product (one guard bit). Divide: partial remainder.
  logic [32:0] acc_q, acc_d;
  // Multiply: multiplier shifting into the low product. Divide: dividend/quotient.
  logic [31:0] quo_q, quo_d;
  // Booth q(-1) bit.
  logic        qm1_q, qm1_d;
  // Multiplicand, or divisor magnitude.
  logic [31:0] opnd_q, opnd_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_pend_q, dz_pend_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hlw_q, hlw_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;

  // Datapath helpers: operand magnitudes, Booth add/sub, restoring trial subtract.
  always_comb begin
    abs_a = op_a[31] ? (~op_a + 32'd1) : op_a;
    abs_b = op_b[31] ? (~op_b + 32'd1) : op_b;
    case ({quo_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + {opnd_q[31], opnd_q};
      2'b10:   booth_sum = acc_q - {opnd_q[31], opnd_q};
      default: booth_sum = acc_q;
    endcase
    div_shift = {acc_q[31:0], quo_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
  end

  // Next-state and next-output logic for the operation sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    qm1_d      = qm1_q;
    opnd_d     = opnd_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hlw_d      = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        // busy stays high through the done cycle, so a start in that cycle is dropped.
        busy_d = 1'b0;
        if (!busy_q && (start_mult || start_div)) begin
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          dz_pend_d  = 1'b0;
          cnt_d      = 5'd0;
          acc_d      = 33'd0;
          qm1_d      = 1'b0;
          neg_quo_d  = 1'b0;
          neg_rem_d  = 1'b0;
          if (start_mult) begin
            opnd_d  = op_a;
            quo_d   = op_b;
            state_d = S_MULT;
`ifdef MULT_DIV_SEQ_ZERO_FAST_EN
            if ((op_a == 32'd0) || (op_b == 32'd0)) begin
              quo_d   = 32'd0;
              state_d = S_DONE;
            end
`endif
          end else begin
            opnd_d    = abs_b;
            quo_d     = abs_a;
            neg_quo_d = op_a[31] ^ op_b[31];
            neg_rem_d = op_a[31];
            if (op_b == 32'd0) begin
              dz_pend_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end
        end
      end

      S_MULT: begin
        // Arithmetic right shift of {acc, quo, q(-1)} after the Booth add/sub.
        acc_d = {booth_sum[32], booth_sum[32:1]};
        quo_d = {booth_sum[0], quo_q[31:1]};
        qm1_d = quo_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end

      S_DIV: begin
        // Keep the trial difference only when it did not go negative.
        if (!div_trial[32]) begin
          acc_d = div_trial;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          acc_d = div_shift;
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        quo_d   = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        acc_d   = {1'b0, (neg_rem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0])};
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_pend_q) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d  = acc_q[31:0];
          lo_d  = quo_q;
          hlw_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 33'd0;
      quo_q      <= 32'd0;
      qm1_q      <= 1'b0;
      opnd_q     <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hlw_q      <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      qm1_q      <= qm1_d;
      opnd_q     <= opnd_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_pend_q  <= dz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hlw_q      <= hlw_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_lo_write = hlw_q;
  assign div_zero    = div_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_seq
//  Purpose  : Self-checking bench for mult_div_seq: directed vector table,
//             busy/reset corner sequences and randomized operations checked
//             against a plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy;
  logic        done;
  logic        hi_lo_write;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULT_DIV_SEQ_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  mult_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .hi_lo_write (hi_lo_write),
    .hi          (hi),
    .lo          (lo),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sm;
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    bit          e_w;
    bit          e_dz;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: full-width signed product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Reference model: {remainder, quotient} from truncating signed division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one start (called with busy=0) and check latency and results.
  task automatic apply(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                       input int e_lat, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input bit e_w, input bit e_dz, input string tag);
    int          lat;
    logic [31:0] g_hi, g_lo;
    logic        g_w, g_dz;
    bit          seen;
    lat = -1; g_hi = '0; g_lo = '0; g_w = 1'b0; g_dz = 1'b0; seen = 1'b0;
    start_mult = sm; start_div = sd; op_a = a; op_b = b;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_dzclr"}, 64'(div_zero), 64'd0);
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = k;
        g_hi = hi; g_lo = lo; g_w = hi_lo_write; g_dz = div_zero;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(e_lat));
    chk({tag, "_hi"}, 64'(g_hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(g_lo), 64'(e_lo));
    chk({tag, "_wr"}, 64'(g_w), 64'(e_w));
    chk({tag, "_dz"}, 64'(g_dz), 64'(e_dz));
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] mh, ml;
    bit          seen;
    int          extra;

    tbl[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h80000000,   32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'd0,          32'd9,        ZLAT, 32'd0,      32'd0,        1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'd3,          32'd5,        33, 32'd0,        32'd15,       1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'd100,        32'd7,        34, 32'd2,        32'd14,       1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'd7,          32'hFFFFFFFE, 34, 32'd1,        32'hFFFFFFFD, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 34, 32'hFFFFFFFE, 32'd14,       1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'd1628201331, 32'd805654952, 33, 32'h12345678, 32'h12345678, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'd5,          32'd0,        1,  32'h12345678, 32'h12345678, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'd3,          32'd5,        34, 32'd3,        32'd0,        1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hlw", 64'(hi_lo_write), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].sm, tbl[i].sd, tbl[i].a, tbl[i].b, tbl[i].lat,
            tbl[i].e_hi, tbl[i].e_lo, tbl[i].e_w, tbl[i].e_dz, $sformatf("vec%0d", i));
    end

    // Starts while busy (mid-operation and in the done cycle) are dropped
    start_mult = 1'b1; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    start_div = 1'b1; op_a = 32'd100; op_b = 32'd3;
    @(negedge clk);
    start_div = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("ign_done", 64'(seen), 64'd1);
    chk("ign_hi", 64'(hi), 64'd0);
    chk("ign_lo", 64'(lo), 64'd42);
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    chk("ign_busy_after", 64'(busy), 64'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("ign_no_queue", 64'(extra), 64'd0);
    chk("ign_lo_hold", 64'(lo), 64'd42);

    // Reset in the middle of a multiply, after an ignored divide request
    start_mult = 1'b1; op_a = 32'h1234; op_b = 32'h5678;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (4) @(negedge clk);
    start_div = 1'b1; op_a = 32'd9; op_b = 32'd3;
    @(negedge clk);
    start_div = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_hi", 64'(hi), 64'd0);
    chk("mrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("mrst_quiet", 64'(extra), 64'd0);

    // Randomized operations against the reference model
    mh = 32'd0;
    ml = 32'd0;
    for (int i = 0; i < 40; i++) begin
      bit          dv;
      logic [31:0] a, b;
      logic [63:0] m;
      dv = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'h80000000;
        default: ;
      endcase
      if (!dv) begin
        m = ref_mul(a, b);
        apply(1'b1, 1'b0, a, b, ((a == 32'd0) || (b == 32'd0)) ? ZLAT : 33,
              m[63:32], m[31:0], 1'b1, 1'b0, "rnd_mul");
        mh = m[63:32];
        ml = m[31:0];
      end else if (b == 32'd0) begin
        apply(1'b0, 1'b1, a, b, 1, mh, ml, 1'b0, 1'b1, "rnd_dz");
      end else begin
        m = ref_div(a, b);
        apply(1'b0, 1'b1, a, b, 34, m[63:32], m[31:0], 1'b1, 1'b0, "rnd_div");
        mh = m[63:32];
        ml = m[31:0];
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_mult  input  1  request a signed 32x32 multiply; sampled only while busy=0.
REQ-005 start_div  input  1  request a signed 32/32 divide; sampled only while busy=0.
REQ-006 op_a  input  32  multiplicand or dividend (two's complement); captured with the start.
REQ-007 op_b  input  32  multiplier or divisor (two's complement); captured with the start.
REQ-008 busy  output  1  operation in progress; high from the cycle after a start is accepted through the done cycle.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 hi_lo_write  output  1  one-cycle write-enable for the HI/LO registers, coincident with done on valid results.
REQ-011 hi  output  32  multiply upper word or divide remainder.
REQ-012 lo  output  32  multiply lower word or divide quotient.
REQ-013 div_zero  output  1  divide-by-zero exception flag, coincident with done.

Function
REQ-014 FSM states SHALL be IDLE, MULT, DIV, FIX, DONE; all outputs registered.
REQ-015 IDLE: start_mult=1 SHALL go to MULT and start_div=1 to DIV, capturing op_a/op_b; if both are asserted, multiply wins and start_div is dropped.
REQ-016 Starts asserted while busy=1 SHALL be ignored, with no queuing.
REQ-017 MULT: Booth radix-2, one iteration per cycle, 32 cycles, then DONE.
REQ-018 DIV: restoring division on magnitudes, 32 cycles, then FIX for 1 cycle, then DONE.
REQ-019 FIX: quotient negated iff operand signs differ; remainder takes the sign of the dividend.
REQ-020 Latency: done SHALL assert 33 cycles (multiply) or 34 cycles (divide) after the accepting edge.
REQ-021 DONE: done=1 and hi_lo_write=1 for one cycle; hi/lo updated on the same edge; next state IDLE, with busy=0 the following cycle.
REQ-022 Divide with op_b=0: IDLE->DONE directly (done 1 cycle after acceptance), div_zero=1, hi_lo_write=0, hi/lo unchanged.
REQ-023 div_zero SHALL clear on the next accepted start.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, with no exception.
REQ-025 Outside DONE, hi/lo SHALL hold the last written result.

Reset
REQ-026 reset=0 SHALL force IDLE asynchronously and clear busy, done, hi_lo_write, div_zero, hi, lo and all internal registers to 0.
REQ-027 A reset mid-operation SHALL abandon the operation without asserting done.
REQ-028 The first start SHALL be sampled no earlier than the first rising edge after reset deassertion.

Configuration
REQ-029 With macro MULT_DIV_SEQ_ZERO_FAST_EN defined, a multiply with op_a=0 or op_b=0 SHALL go IDLE->DONE, with done 1 cycle after acceptance, hi=lo=0 and hi_lo_write=1.
REQ-030 With MULT_DIV_SEQ_ZERO_FAST_EN undefined, all multiplies SHALL take 33 cycles.
REQ-031 Divide behaviour SHALL be identical in both configurations.

Verification
REQ-032 Multiply 7 x 0xFFFFFFFD (-3) -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, hi_lo_write=1.
REQ-033 Multiply 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 Divide 0xFFFFFFF9 (-7) / 2 -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 Divide 5 / 0 with prior hi=lo=0x12345678 -> done 1 cycle later, div_zero=1, hi_lo_write=0, hi=lo=0x12345678.
REQ-036 start_div pulsed at cycle 5 of a multiply, then reset=0 at cycle 10 -> divide ignored, busy=0 immediately, no done, hi=lo=0.
REQ-037 Multiply 0 x 9 -> done at cycle 1 with MULT_DIV_SEQ_ZERO_FAST_EN, at cycle 33 without; hi=lo=0 in both cases.
